// File: rtl/cle_stat.sv
// Post-labeling statistics: scans the 32x32 label map, accumulates per-label count and
// bounding box, then streams one record per label. `CLE_STAT_BBOX_EN builds the bbox logic.

module cle_stat_entry (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        alloc,
  input  logic        upd,
  input  logic [7:0]  pix,
  input  logic [4:0]  row,
  input  logic [4:0]  col,
  output logic [7:0]  label,
  output logic [10:0] count,
  output logic [4:0]  rmin,
  output logic [4:0]  rmax,
  output logic [4:0]  cmin,
  output logic [4:0]  cmax
);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      label <= '0;
      count <= '0;
    end else if (clr) begin
      label <= '0;
      count <= '0;
    end else if (alloc) begin
      label <= pix;
      count <= 11'd1;
    end else if (upd) begin
      count <= count + 11'd1;
    end
  end

`ifdef CLE_STAT_BBOX_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rmin <= '0; rmax <= '0; cmin <= '0; cmax <= '0;
    end else if (clr) begin
      rmin <= '0; rmax <= '0; cmin <= '0; cmax <= '0;
    end else if (alloc) begin
      rmin <= row; rmax <= row; cmin <= col; cmax <= col;
    end else if (upd) begin
      if (row < rmin) rmin <= row;
      if (row > rmax) rmax <= row;
      if (col < cmin) cmin <= col;
      if (col > cmax) cmax <= col;
    end
  end
`else
  logic unused_bbox;
  assign unused_bbox = ^{row, col};
  assign rmin = '0;
  assign rmax = '0;
  assign cmin = '0;
  assign cmax = '0;
`endif
endmodule

module cle_stat #(
  parameter int MAX_LABELS = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  sram_q,
  output logic [9:0]  sram_a,
  output logic        sram_wen,
  output logic        busy,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_label,
  output logic [10:0] out_count,
  output logic [4:0]  out_rmin,
  output logic [4:0]  out_rmax,
  output logic [4:0]  out_cmin,
  output logic [4:0]  out_cmax,
  output logic        overflow,
  output logic        done
);
  localparam int CW = $clog2(MAX_LABELS + 1);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_DRAIN, S_OUT, S_DONE} state_t;
  state_t state, state_nxt;

  logic [9:0]    rd_addr;
  logic          rd_vld;
  logic [CW-1:0] n_used, out_idx;
  logic          clr, any_hit, full, new_lbl, do_alloc, drop, last;

  logic [MAX_LABELS-1:0]       hit, alloc;
  logic [MAX_LABELS-1:0][7:0]  ent_label;
  logic [MAX_LABELS-1:0][10:0] ent_count;
  logic [MAX_LABELS-1:0][4:0]  ent_rmin, ent_rmax, ent_cmin, ent_cmax;

  assign clr      = (state == S_IDLE) && start;
  assign any_hit  = |hit;
  assign full     = (n_used == CW'(MAX_LABELS));
  assign new_lbl  = rd_vld && (sram_q != 8'd0) && !any_hit;
  assign do_alloc = new_lbl && !full;
  assign drop     = new_lbl && full;
  assign last     = ((out_idx + CW'(1)) == n_used);

  // One entry per table slot; match is a parallel compare against occupied slots only.
  for (genvar i = 0; i < MAX_LABELS; i++) begin : g_ent
    assign hit[i]   = rd_vld && (n_used > CW'(i)) && (ent_label[i] == sram_q);
    assign alloc[i] = do_alloc && (n_used == CW'(i));
    cle_stat_entry u_ent (
      .clk(clk), .reset_n(reset_n), .clr(clr), .alloc(alloc[i]), .upd(hit[i]),
      .pix(sram_q), .row(rd_addr[9:5]), .col(rd_addr[4:0]),
      .label(ent_label[i]), .count(ent_count[i]),
      .rmin(ent_rmin[i]), .rmax(ent_rmax[i]), .cmin(ent_cmin[i]), .cmax(ent_cmax[i])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SCAN;
      S_SCAN:  if (sram_a == 10'd1023) state_nxt = S_DRAIN;
      // the final pixel may allocate on this very edge
      S_DRAIN: state_nxt = ((n_used != '0) || do_alloc) ? S_OUT : S_DONE;
      S_OUT:   if (out_ready && last) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    out_valid = (state == S_OUT);
    sram_wen  = 1'b1;
    out_label = '0;
    out_count = '0;
    out_rmin  = '0;
    out_rmax  = '0;
    out_cmin  = '0;
    out_cmax  = '0;
    for (int i = 0; i < MAX_LABELS; i++) begin
      if (out_valid && (out_idx == CW'(i))) begin
        out_label = ent_label[i];
        out_count = ent_count[i];
        out_rmin  = ent_rmin[i];
        out_rmax  = ent_rmax[i];
        out_cmin  = ent_cmin[i];
        out_cmax  = ent_cmax[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_a   <= '0;
      rd_addr  <= '0;
      rd_vld   <= 1'b0;
      n_used   <= '0;
      out_idx  <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= (state == S_DONE);
      rd_vld  <= (state == S_SCAN);
      rd_addr <= sram_a;
      if (state == S_SCAN) sram_a <= sram_a + 10'd1;
      else                 sram_a <= '0;
      if (clr) begin
        n_used   <= '0;
        out_idx  <= '0;
        overflow <= 1'b0;
      end else begin
        if (do_alloc) n_used <= n_used + CW'(1);
        if (drop)     overflow <= 1'b1;
        if ((state == S_OUT) && out_ready) out_idx <= out_idx + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_cle_stat.sv
// Randomized bench for cle_stat: a label-map model predicts records, overflow and
// the exact cycle of every handshake, done pulse and busy edge.

module tb_cle_stat;
  localparam int ML = 8;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, out_ready = 1'b0;
  logic [7:0]  sram_q = 8'd0;
  logic [9:0]  sram_a;
  logic        sram_wen, busy, out_valid, overflow, done;
  logic [7:0]  out_label;
  logic [10:0] out_count;
  logic [4:0]  out_rmin, out_rmax, out_cmin, out_cmax;

  cle_stat #(.MAX_LABELS(ML)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sram_q(sram_q), .sram_a(sram_a),
    .sram_wen(sram_wen), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .out_count(out_count), .out_rmin(out_rmin), .out_rmax(out_rmax),
    .out_cmin(out_cmin), .out_cmax(out_cmax), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [1024];
  always @(posedge clk) sram_q <= mem[sram_a];

  int gcnt = 0;
  always @(posedge clk) gcnt <= gcnt + 1;

  typedef struct {int label; int count; int rmin; int rmax; int cmin; int cmax;} rec_t;
  rec_t exp_q[$];
  bit   exp_ovf;
  int   ntests = 0, nfail = 0;
  int   t0 = 0, rec_idx = 0, done_cyc = 0, jobs_done = 0, rmode = 0;
  bit   job_on = 1'b0;

  task automatic chk(input string name, input int act, input int expv);
    ntests++;
    if (act != expv) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic int bx(input int v);
`ifdef CLE_STAT_BBOX_EN
    return v;
`else
    return 0;
`endif
  endfunction

  // Label table in scan order: first-seen labels get slots until the table is full.
  function automatic void build_model();
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      int v, r, c, f;
      rec_t t;
      v = int'(mem[a]);
      r = a / 32;
      c = a % 32;
      f = -1;
      if (v == 0) continue;
      for (int j = 0; j < exp_q.size(); j++) if (exp_q[j].label == v) f = j;
      if (f >= 0) begin
        t = exp_q[f];
        t.count++;
        if (r < t.rmin) t.rmin = r;
        if (r > t.rmax) t.rmax = r;
        if (c < t.cmin) t.cmin = c;
        if (c > t.cmax) t.cmax = c;
        exp_q[f] = t;
      end else if (exp_q.size() < ML) begin
        t = '{v, 1, r, r, c, c};
        exp_q.push_back(t);
      end else exp_ovf = 1'b1;
    end
  endfunction

  task automatic clear_map();
    for (int a = 0; a < 1024; a++) mem[a] = 8'd0;
  endtask

  task automatic random_map();
    int nl;
    logic [7:0] lbl [12];
    nl = $urandom_range(1, 12);
    for (int j = 0; j < 12; j++) lbl[j] = 8'($urandom_range(1, 255));
    for (int a = 0; a < 1024; a++)
      mem[a] = (($urandom % 8) == 0) ? lbl[$urandom_range(0, nl - 1)] : 8'd0;
  endtask

  task automatic run_job(input int mode, input bit ostart);
    int jd, guard, c;
    build_model();
    rmode    = mode;
    rec_idx  = 0;
    done_cyc = (exp_q.size() == 0) ? 1026 : 32'h3fff_ffff;
    @(posedge clk); #1;
    t0 = gcnt + 1;
    start = 1'b1;
    job_on = 1'b1;
    jd = jobs_done;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (jobs_done == jd && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      c = gcnt - t0;
      start = ostart && (c == 1026);
    end
    start = 1'b0;
    if (jobs_done == jd) chk("job_timeout", 0, 1);
    job_on = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sram_a"}, sram_a, 0);
    chk({tag, "_sram_wen"}, sram_wen, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_out_data"}, int'({out_label, out_count}), 0);
    chk({tag, "_out_bbox"}, int'({out_rmin, out_rmax, out_cmin, out_cmax}), 0);
  endtask

  initial begin
    fork
      forever begin : monitor
        int cyc;
        bit ev;
        @(negedge clk);
        if (job_on) begin
          cyc = gcnt - t0;
          if (cyc >= 0) begin
            chk("sram_wen", sram_wen, 1);
            if (cyc <= 1023) chk("sram_a", sram_a, cyc);
            if (cyc == 0) chk("ovf_cleared", overflow, 0);
            ev = (cyc >= 1025) && (rec_idx < exp_q.size());
            chk("out_valid", out_valid, int'(ev));
            if (ev) begin
              chk("out_label", out_label, exp_q[rec_idx].label);
              chk("out_count", out_count, exp_q[rec_idx].count);
              chk("out_rmin", out_rmin, bx(exp_q[rec_idx].rmin));
              chk("out_rmax", out_rmax, bx(exp_q[rec_idx].rmax));
              chk("out_cmin", out_cmin, bx(exp_q[rec_idx].cmin));
              chk("out_cmax", out_cmax, bx(exp_q[rec_idx].cmax));
              chk("ovf_out", overflow, int'(exp_ovf));
              if (out_ready) begin
                rec_idx++;
                if (rec_idx == exp_q.size()) done_cyc = cyc + 2;
              end
            end
            chk("done", done, int'(cyc == done_cyc));
            chk("busy", busy, int'(cyc < done_cyc));
            if (cyc == done_cyc) begin
              chk("ovf_end", overflow, int'(exp_ovf));
              chk("records", rec_idx, exp_q.size());
              jobs_done++;
            end
          end
        end
      end
      forever begin : ready_drv
        int c;
        @(posedge clk); #1;
        c = gcnt - t0;
        case (rmode)
          0:       out_ready = 1'b1;
          1:       out_ready = (($urandom % 4) != 0);
          default: out_ready = !(c >= 1025 && c <= 1027);
        endcase
      end
    join_none

    clear_map();
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // all-zero map
    build_model();
    chk("model_empty", exp_q.size(), 0);
    run_job(0, 1'b0);

    // single pixel at row 1, col 1
    mem[33] = 8'h05;
    build_model();
    chk("model_single_label", exp_q[0].label, 5);
    chk("model_single_box", exp_q[0].rmin * 1000 + exp_q[0].cmax, 1001);
    run_job(0, 1'b0);

    // full map of one label
    for (int a = 0; a < 1024; a++) mem[a] = 8'h01;
    build_model();
    chk("model_full_count", exp_q[0].count, 1024);
    chk("model_full_box", exp_q[0].rmax * 100 + exp_q[0].cmax, 3131);
    run_job(1, 1'b0);

    // nine labels, table of eight
    clear_map();
    for (int a = 0; a < 9; a++) mem[a] = 8'(a + 1);
    build_model();
    chk("model_ovf_size", exp_q.size(), 8);
    chk("model_ovf_flag", int'(exp_ovf), 1);
    run_job(0, 1'b0);

    // backpressure on the first record plus a start pulse during OUT
    clear_map();
    mem[40] = 8'h11; mem[100] = 8'h2a; mem[200] = 8'h2a;
    build_model();
    chk("model_bp_order", exp_q[0].label, 8'h11);
    chk("model_bp_count", exp_q[1].count, 2);
    run_job(2, 1'b1);

    // reset while sram_a = 500, then a clean rerun of the same map
    random_map();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (500) @(posedge clk);
    #1;
    chk("mid_sram_a", sram_a, 500);
    chk("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    run_job(1, 1'b0);

    for (int k = 0; k < 5; k++) begin
      random_map();
      run_job(k % 3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
